bullet_ctrl: RTL and testbench

- Upstream motion/state stage for a bullet sprite: turns a fire request and shooter position into per-frame bullet centre coordinates (x, y) plus an active flag.
- Feeds the circular bullet renderer, which compares hcount/vcount against x/y with the same radius R; the pixel mux gates that renderer with `active`.
- Position updates once per frame on `frame_tick`, so coordinates are stable during active video.

---
 rtl/bullet_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_bullet_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bullet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bullet_ctrl
// Purpose  : Motion/state stage for one bullet sprite. A rising edge on fire
//            launches the bullet from the shooter position. It then climbs
//            SPEED pixels per frame until it would cross the top edge, or
//            until a collision freezes it in a HIT flash for HIT_FRAMES
//            frames.
// Ports    : clk, rst_n (async assert, active low)
//            frame_tick  one-clk pulse per frame (start of vblank)
//            fire        debounced fire button (level)
//            shoot_x/y   shooter centre, captured at launch
//            hit         one-clk collision pulse
//            x, y        registered bullet centre
//            active      bullet is drawn (FLY or HIT)
//            flash       HIT state indicator (colour swap)
//            shots       launched-bullet count, saturating at 255
// Options  : BULLET_CTRL_AUTO_FIRE_EN - holding fire in IDLE relaunches
//            every COOLDOWN frames.
// Revision : 1.0 - initial release
// ============================================================================
module bullet_ctrl #(
  parameter int R          = 12,
  parameter int SPEED      = 4,
  parameter int HIT_FRAMES = 8,
  parameter int COOLDOWN   = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        fire,
  input  logic [10:0] shoot_x,
  input  logic [9:0]  shoot_y,
  input  logic        hit,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        active,
  output logic        flash,
  output logic [7:0]  shots
);

  localparam int        HCW      = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
  localparam [HCW-1:0]  C_HIT_LAST = HCW'(HIT_FRAMES - 1);
  // The bullet may take one more step only if it stays at or below R after
  // the step. Comparing before subtracting keeps the 10-bit y from wrapping.
  localparam [9:0]      C_TOP    = 10'(R + SPEED);
  localparam [9:0]      C_SPEED  = 10'(SPEED);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_HIT  = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_fire_q;
  logic            w_launch_edge;
  logic            w_auto;
  logic            w_go;
  logic [HCW-1:0]  r_hit_cnt, w_hit_cnt_nxt;
  logic [10:0]     w_x_nxt;
  logic [9:0]      w_y_nxt;
  logic            w_active_nxt;
  logic            w_flash_nxt;
  logic [7:0]      w_shots_nxt;

  assign w_launch_edge = fire & ~r_fire_q;

`ifdef BULLET_CTRL_AUTO_FIRE_EN
  localparam int       CDW  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam [CDW-1:0] C_CD = CDW'(COOLDOWN);

  logic [CDW-1:0] r_cd_cnt, w_cd_nxt;

  assign w_auto = fire && (r_cd_cnt == C_CD);

  // Counts frames spent in IDLE with fire held; any launch or release of
  // fire restarts the cooldown.
  always_comb begin
    w_cd_nxt = r_cd_cnt;
    if (!fire) begin
      w_cd_nxt = '0;
    end else if (r_state == ST_IDLE) begin
      if (w_go) begin
        w_cd_nxt = '0;
      end else if (frame_tick) begin
        w_cd_nxt = r_cd_cnt + CDW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cd_cnt <= '0;
    end else begin
      r_cd_cnt <= w_cd_nxt;
    end
  end
`else
  assign w_auto = 1'b0;
`endif

  assign w_go = w_launch_edge | w_auto;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_fire_q  <= 1'b0;
      r_hit_cnt <= '0;
      x         <= '0;
      y         <= '0;
      active    <= 1'b0;
      flash     <= 1'b0;
      shots     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_fire_q  <= fire;
      r_hit_cnt <= w_hit_cnt_nxt;
      x         <= w_x_nxt;
      y         <= w_y_nxt;
      active    <= w_active_nxt;
      flash     <= w_flash_nxt;
      shots     <= w_shots_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_hit_cnt_nxt = r_hit_cnt;
    w_x_nxt       = x;
    w_y_nxt       = y;
    w_active_nxt  = active;
    w_flash_nxt   = flash;
    w_shots_nxt   = shots;

    unique case (r_state)
      ST_IDLE: begin
        // hit is meaningless with no bullet on screen; launch does not
        // wait for frame_tick.
        if (w_go) begin
          w_state_nxt  = ST_FLY;
          w_x_nxt      = shoot_x;
          w_y_nxt      = shoot_y;
          w_active_nxt = 1'b1;
          w_flash_nxt  = 1'b0;
          if (shots != 8'hFF) begin
            w_shots_nxt = shots + 8'd1;
          end
        end
      end

      ST_FLY: begin
        // A collision outranks a same-cycle top exit.
        if (hit) begin
          w_state_nxt   = ST_HIT;
          w_hit_cnt_nxt = '0;
          w_flash_nxt   = 1'b1;
        end else if (frame_tick) begin
          if (y >= C_TOP) begin
            w_y_nxt = y - C_SPEED;
          end else begin
            w_state_nxt  = ST_IDLE;
            w_active_nxt = 1'b0;
          end
        end
      end

      ST_HIT: begin
        if (frame_tick) begin
          if (r_hit_cnt == C_HIT_LAST) begin
            w_state_nxt  = ST_IDLE;
            w_active_nxt = 1'b0;
            w_flash_nxt  = 1'b0;
          end else begin
            w_hit_cnt_nxt = r_hit_cnt + HCW'(1);
          end
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_active_nxt = 1'b0;
        w_flash_nxt  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bullet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bullet_ctrl
// Purpose  : Directed self-checking bench for bullet_ctrl with default
//            parameters (R=12, SPEED=4, HIT_FRAMES=8, COOLDOWN=15).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bullet_ctrl;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        fire;
  logic [10:0] shoot_x;
  logic [9:0]  shoot_y;
  logic        hit;
  logic [10:0] x;
  logic [9:0]  y;
  logic        active;
  logic        flash;
  logic [7:0]  shots;

  int n_vec  = 0;
  int n_miss = 0;

  bullet_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .fire       (fire),
    .shoot_x    (shoot_x),
    .shoot_y    (shoot_y),
    .hit        (hit),
    .x          (x),
    .y          (y),
    .active     (active),
    .flash      (flash),
    .shots      (shots)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs for one clock, then sample 1 ns after the edge.
  task automatic cyc(input logic f, input logic ft, input logic h);
    fire       = f;
    frame_tick = ft;
    hit        = h;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    hit        = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [10:0] ex, input logic [9:0] ey,
                         input logic ea, input logic ef, input logic [7:0] es);
    chk({tag, ".x"},      32'(x),      32'(ex));
    chk({tag, ".y"},      32'(y),      32'(ey));
    chk({tag, ".active"}, 32'(active), 32'(ea));
    chk({tag, ".flash"},  32'(flash),  32'(ef));
    chk({tag, ".shots"},  32'(shots),  32'(es));
  endtask

  initial begin
    rst_n      = 1'b0;
    fire       = 1'b0;
    frame_tick = 1'b0;
    hit        = 1'b0;
    shoot_x    = 11'd0;
    shoot_y    = 10'd0;

    // ---- Reset state
    #12;
    chk_all("reset", 11'd0, 10'd0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("idle", 11'd0, 10'd0, 1'b0, 1'b0, 8'd0);

    // ---- Launch at (320,400), then three frames upward
    shoot_x = 11'd320; shoot_y = 10'd400;
    cyc(1'b1, 1'b0, 1'b0);
    chk_all("launch", 11'd320, 10'd400, 1'b1, 1'b0, 8'd1);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
    chk_all("fly3", 11'd320, 10'd388, 1'b1, 1'b0, 8'd1);

    // ---- Second fire edge during FLY is discarded
    shoot_x = 11'd7; shoot_y = 10'd9;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk_all("fly_refire", 11'd320, 10'd388, 1'b1, 1'b0, 8'd1);

    // ---- Hit at y=388; further hits and fire edges inside HIT are ignored
    cyc(1'b0, 1'b0, 1'b1);
    chk_all("hit_enter", 11'd320, 10'd388, 1'b1, 1'b1, 8'd1);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    chk_all("hit_7ticks", 11'd320, 10'd388, 1'b1, 1'b1, 8'd1);
    cyc(1'b0, 1'b1, 1'b0);
    chk_all("hit_8th", 11'd320, 10'd388, 1'b0, 1'b0, 8'd1);

    // ---- Hit at y=200: frozen for exactly 8 frames
    shoot_x = 11'd100; shoot_y = 10'd200;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk_all("hit200", 11'd100, 10'd200, 1'b1, 1'b1, 8'd2);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0);
    chk_all("hit200_7", 11'd100, 10'd200, 1'b1, 1'b1, 8'd2);
    cyc(1'b0, 1'b1, 1'b0);
    chk_all("hit200_8", 11'd100, 10'd200, 1'b0, 1'b0, 8'd2);

    // ---- Top exit from y=20: 16, 12, then leave with y held at 12
    shoot_x = 11'd50; shoot_y = 10'd20;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("exit_t1.y", 32'(y), 32'd16);
    cyc(1'b0, 1'b1, 1'b0);
    chk("exit_t2.y", 32'(y), 32'd12);
    cyc(1'b0, 1'b1, 1'b0);
    chk_all("exit_t3", 11'd50, 10'd12, 1'b0, 1'b0, 8'd3);
    // hit and frame_tick in IDLE change nothing
    cyc(1'b0, 1'b1, 1'b1);
    chk_all("idle_hit", 11'd50, 10'd12, 1'b0, 1'b0, 8'd3);

    // ---- hit coincident with top-exit tick: HIT wins
    shoot_x = 11'd60; shoot_y = 10'd12;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk_all("hit_vs_exit", 11'd60, 10'd12, 1'b1, 1'b1, 8'd4);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("hit_vs_exit_done.active", 32'(active), 32'd0);

    // ---- Launch coincident with frame_tick: no move on that tick
    shoot_x = 11'd640; shoot_y = 10'd400;
    cyc(1'b1, 1'b1, 1'b0);
    chk_all("launch_tick", 11'd640, 10'd400, 1'b1, 1'b0, 8'd5);
    cyc(1'b0, 1'b1, 1'b0);
    chk("launch_tick_next.y", 32'(y), 32'd396);

    // ---- Mid-flight asynchronous reset
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("midreset", 11'd0, 10'd0, 1'b0, 1'b0, 8'd0);
    #2;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);

    // ---- Fire held through bullet exit
    shoot_x = 11'd10; shoot_y = 10'd0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("hold_launch.shots", 32'(shots), 32'd1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("hold_exit.active", 32'(active), 32'd0);
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("hold_15.active", 32'(active), 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
`ifdef BULLET_CTRL_AUTO_FIRE_EN
    chk_all("auto_relaunch", 11'd10, 10'd0, 1'b1, 1'b0, 8'd2);
`else
    chk_all("no_relaunch", 11'd10, 10'd0, 1'b0, 1'b0, 8'd1);
`endif
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // ---- Saturating shot counter over 256 launches
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    shoot_x = 11'd5; shoot_y = 10'd0;
    for (int i = 0; i < 255; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
    end
    chk("sat_255.shots", 32'(shots), 32'd255);
    cyc(1'b1, 1'b0, 1'b0);
    chk("sat_256.active", 32'(active), 32'd1);
    chk("sat_256.shots", 32'(shots), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
